// File: rtl/lstm_acc_pkg.sv
// rtl/lstm_acc_pkg.sv - shared types and sizing helpers for the LSTM input path
package lstm_acc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        FEED,
        WAIT_DONE,
        HANDOFF,
        FINISH
    } seq_state_e;

    localparam int DEFAULT_FEATURES = 4;
    localparam int ELEMS_PER_STEP   = 2 * DEFAULT_FEATURES;

    // A frame carries two parallel vectors worth of elements
    function automatic int elems_for(input int features);
        return 2 * features;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// rtl/ctrl_watchdog.sv - cycle watchdog for deserializer completion, built only with DESER_TIMEOUT_EN
`ifdef DESER_TIMEOUT_EN
module ctrl_watchdog #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (enable) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Fires on the LIMIT-th enabled cycle so the caller can leave on that edge
    assign expire = enable && (cnt_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/deser_seq_ctrl.sv
// rtl/deser_seq_ctrl.sv - per-timestep deserializer sequencer; watchdog enabled by DESER_TIMEOUT_EN
module deser_seq_ctrl
    import lstm_acc_pkg::*;
#(
    parameter int FEATURES     = DEFAULT_FEATURES,
    parameter int ELEMENT_BITS = 8,
    parameter int STEP_W       = 8,
    parameter int TIMEOUT      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    seq_start,
    input  logic                    seq_abort,
    input  logic [STEP_W-1:0]       cfg_num_steps,
    output logic                    seq_busy,
    output logic                    seq_done,
    input  logic                    src_frame_avail,
    input  logic [ELEMENT_BITS-1:0] src_data,
    output logic                    src_rd_en,
    output logic                    deser_start,
    output logic [ELEMENT_BITS-1:0] deser_data,
    input  logic                    deser_done,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    vec_last,
    output logic [STEP_W-1:0]       step_idx,
    output logic                    seq_err
);
    localparam int ELEMS = elems_for(FEATURES);
    localparam int EW    = cnt_width(ELEMS);
    localparam logic [EW-1:0] ELEM_LAST = EW'(ELEMS - 1);

    seq_state_e        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [STEP_W-1:0] count_q, count_d;
    logic [EW-1:0]     elem_q, elem_d;
    logic              last_step;
    logic              wd_expire;

    assign last_step = (step_q == count_q - STEP_W'(1));

`ifdef DESER_TIMEOUT_EN
    logic err_q;

    ctrl_watchdog #(.LIMIT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .enable (state_q == WAIT_DONE && !deser_done),
        .clear  (state_q != WAIT_DONE),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && seq_start && !seq_abort) begin
            err_q <= 1'b0;
        end else if (wd_expire) begin
            err_q <= 1'b1;
        end
    end

    assign seq_err = err_q;
`else
    assign wd_expire = 1'b0;
    assign seq_err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= '0;
            count_q <= '0;
            elem_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            count_q <= count_d;
            elem_q  <= elem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        count_d = count_q;
        elem_d  = elem_q;
        case (state_q)
            IDLE: begin
                if (seq_start) begin
                    count_d = cfg_num_steps;
                    step_d  = '0;
                    state_d = (cfg_num_steps == '0) ? FINISH : ARM;
                end
            end
            ARM: begin
                if (src_frame_avail) state_d = START;
            end
            START: begin
                elem_d  = '0;
                state_d = FEED;
            end
            FEED: begin
                if (elem_q == ELEM_LAST) begin
                    elem_d  = '0;
                    state_d = WAIT_DONE;
                end else begin
                    elem_d = elem_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (deser_done) begin
                    state_d = HANDOFF;
                end else if (wd_expire) begin
                    state_d = IDLE;
                    step_d  = '0;
                end
            end
            HANDOFF: begin
                if (vec_ready) begin
                    if (last_step) begin
                        state_d = FINISH;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = ARM;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
                step_d  = '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Abort outranks every transition above, including a same-cycle handshake
        if (seq_abort) begin
            state_d = IDLE;
            step_d  = '0;
            elem_d  = '0;
        end
    end

    assign seq_busy    = (state_q != IDLE);
    assign seq_done    = (state_q == FINISH);
    assign deser_start = (state_q == START);
    assign src_rd_en   = (state_q == FEED);
    assign deser_data  = src_rd_en ? src_data : '0;
    assign vec_valid   = (state_q == HANDOFF);
    assign vec_last    = vec_valid && last_step;
    assign step_idx    = step_q;

endmodule

// File: tb/tb_deser_seq_ctrl.sv
// tb/tb_deser_seq_ctrl.sv - randomized self-checking bench for deser_seq_ctrl
module tb_deser_seq_ctrl;
    localparam int FEATURES = 4;
    localparam int EB       = 8;
    localparam int SW       = 8;
    localparam int TIMEOUT  = 16;
    localparam int ELEMS    = 2 * FEATURES;

    logic          clk = 1'b0;
    logic          reset;
    logic          seq_start, seq_abort;
    logic [SW-1:0] cfg_num_steps;
    logic          seq_busy, seq_done;
    logic          src_frame_avail;
    logic [EB-1:0] src_data;
    logic          src_rd_en, deser_start;
    logic [EB-1:0] deser_data;
    logic          deser_done;
    logic          vec_valid, vec_ready, vec_last;
    logic [SW-1:0] step_idx;
    logic          seq_err;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EB-1:0] fifo[$];

    always #5 clk = ~clk;

    deser_seq_ctrl #(
        .FEATURES(FEATURES), .ELEMENT_BITS(EB), .STEP_W(SW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .seq_start(seq_start), .seq_abort(seq_abort),
        .cfg_num_steps(cfg_num_steps), .seq_busy(seq_busy), .seq_done(seq_done),
        .src_frame_avail(src_frame_avail), .src_data(src_data), .src_rd_en(src_rd_en),
        .deser_start(deser_start), .deser_data(deser_data), .deser_done(deser_done),
        .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_last(vec_last),
        .step_idx(step_idx), .seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic drive_src(input bit block);
        src_frame_avail = !block && (fifo.size() >= ELEMS);
        src_data = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    // One sequence from seq_start to a few idle cycles after it ends.
    // rmode: 0 random ready, 1 always ready, 2 ready low for 5 valid cycles.
    task automatic run_seq(input int n, input int abort_at, input bit no_done,
                           input int rmode, input int hold);
        int cyc = 0, since = -1, fed = 0, hs = 0, dones = 0, starts = 0;
        int last_hs = -100, last_rd = -1, done_cnt = -1, done_drv = -100;
        int vrun = 0, post = 0, first_start = -1, prev_step = 0;
        bit prev_avail, prev_hold = 0, done_seen = 0, aborted = 0;
        bit timed_out, exp_busy, r;
        seq_start = 1'b1;
        cfg_num_steps = SW'(n);
        drive_src(hold > 0);
        prev_avail = src_frame_avail;
        while (post < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            timed_out = no_done && last_rd >= 0 && cyc > last_rd + TIMEOUT;
            exp_busy  = !(done_seen || aborted || timed_out);
            chk("busy", seq_busy, exp_busy);
`ifdef DESER_TIMEOUT_EN
            chk("seq_err", seq_err, timed_out);
`else
            chk("seq_err", seq_err, 0);
`endif
            if (!exp_busy) chk("idle_step", step_idx, 0);

            if (deser_start) begin
                starts++;
                chk("start_avail", prev_avail, 1);
                since = 0;
                fed = 0;
                if (first_start < 0) first_start = cyc;
            end else if (since >= 0) begin
                since++;
            end
            chk("rd_window", src_rd_en, since >= 1 && since <= ELEMS);
            if (src_rd_en) begin
                chk("deser_data", deser_data, fifo.size() != 0 ? 32'(fifo[0]) : 32'hffff_ffff);
                if (fifo.size() != 0) void'(fifo.pop_front());
                fed++;
                if (fed == ELEMS) begin
                    last_rd = cyc;
                    if (!no_done) done_cnt = $urandom_range(2, 5);
                end
            end else begin
                chk("deser_data_idle", deser_data, 0);
            end

            if (prev_hold) begin
                chk("valid_hold", vec_valid, 1);
                chk("step_hold", step_idx, prev_step);
            end
            if (vec_valid) begin
                if (vrun == 0) chk("handoff_lat", cyc, done_drv + 1);
                vrun++;
                chk("step_idx", step_idx, hs);
                chk("vec_last", vec_last, hs == n - 1);
            end else begin
                chk("vec_last_idle", vec_last, 0);
            end

            if (seq_done) begin
                dones++;
                chk("done_timing", cyc, n == 0 ? 1 : last_hs + 1);
                done_seen = 1'b1;
            end

            seq_start  = 1'b0;
            seq_abort  = 1'b0;
            deser_done = 1'b0;
            cfg_num_steps = SW'($urandom);
            if (cyc == 3 && n > 0 && abort_at == 0) begin
                seq_start = 1'b1;
                cfg_num_steps = SW'(n + 2);
            end
            if (abort_at > 0 && !aborted && src_rd_en && fed == abort_at) begin
                seq_abort = 1'b1;
                aborted = 1'b1;
                since = -1;
                done_cnt = -1;
            end
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin
                    deser_done = 1'b1;
                    done_drv = cyc;
                    done_cnt = -1;
                end
            end else if (since >= 1 && since < ELEMS && $urandom_range(0, 3) == 0) begin
                deser_done = 1'b1;
            end

            case (rmode)
                1:       r = 1'b1;
                2:       r = (vrun > 5);
                default: r = 1'($urandom_range(0, 1));
            endcase
            vec_ready = r;
            if (vec_valid && r && !aborted) begin
                hs++;
                last_hs = cyc;
                vrun = 0;
            end
            prev_hold = vec_valid && !r && !aborted;
            prev_step = int'(step_idx);

            if (fifo.size() < 3 * ELEMS && $urandom_range(0, 2) == 0) fifo.push_back(8'($urandom));
            drive_src(cyc < hold);
            prev_avail = src_frame_avail;
            if (done_seen || aborted || timed_out) post++;
        end
        chk("seq_bound", post >= 4, 1);
        chk("done_count", dones, (aborted || no_done) ? 0 : 1);
        chk("starts", starts, (aborted || no_done) ? 1 : n);
        chk("handshakes", hs, (aborted || no_done) ? 0 : n);
        if (hold > 0 && n > 0) chk("start_after_hold", first_start > hold, 1);
    endtask

    initial begin
        reset = 1'b1;
        seq_start = 1'b0;
        seq_abort = 1'b0;
        cfg_num_steps = '0;
        deser_done = 1'b0;
        vec_ready = 1'b0;
        for (int i = 1; i <= ELEMS; i++) fifo.push_back(8'(i));
        drive_src(1'b0);
        repeat (3) @(negedge clk);
        chk("rst_busy", seq_busy, 0);
        chk("rst_done", seq_done, 0);
        chk("rst_rd_en", src_rd_en, 0);
        chk("rst_start", deser_start, 0);
        chk("rst_data", deser_data, 0);
        chk("rst_valid", vec_valid, 0);
        chk("rst_last", vec_last, 0);
        chk("rst_step", step_idx, 0);
        chk("rst_err", seq_err, 0);
        reset = 1'b0;
        @(negedge clk);

        run_seq(1, 0, 1'b0, 1, 0);
        run_seq(3, 0, 1'b0, 2, 0);
        run_seq(0, 0, 1'b0, 0, 0);
        run_seq(2, 3, 1'b0, 0, 0);
        run_seq(2, 0, 1'b0, 0, 0);
        run_seq(2, 0, 1'b0, 0, 10);
`ifdef DESER_TIMEOUT_EN
        run_seq(1, 0, 1'b1, 1, 0);
        repeat (2) @(negedge clk);
        chk("err_sticky", seq_err, 1);
        run_seq(1, 0, 1'b0, 1, 0);
`endif
        for (int k = 0; k < 8; k++) begin
            run_seq($urandom_range(0, 4), 0, 1'b0, 0, $urandom_range(0, 3));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
